// File: rtl/sine_pkg.sv
// Shared constants, quadrant encoding and quarter-wave ROM contents for sine_phase_gen.
package sine_pkg;

  localparam int unsigned PHASE_W    = 24;
  localparam int unsigned LUT_ADDR_W = 7;
  localparam int unsigned OUT_W      = 10;
  localparam int unsigned MIDSCALE   = 2 ** (OUT_W - 1);

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  // round(511*sin(pi/2*(k+0.5)/2^addr_w)); Taylor series keeps it a plain constant function
  function automatic int sine_q(input int k, input int addr_w);
    real x;
    real term;
    real sum;
    x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(2 ** addr_w);
    term = x;
    sum  = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return $rtoi(511.0 * sum + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Synchronous-read quarter-wave sine ROM, contents computed at elaboration.
module sine_quarter_rom #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  import sine_pkg::*;

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rom [DEPTH];
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = DATA_W'(sine_q(k, int'(ADDR_W)));
  end

  always_comb begin
    data_d = data_q;
    if (rd_en) begin
      data_d = rom[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/sine_phase_gen.sv
// Phase accumulator + quarter-wave fold + sign stage producing offset-binary sine
// samples over a valid/ready handshake.
module sine_phase_gen #(
  parameter int unsigned PHASE_W    = sine_pkg::PHASE_W,
  parameter int unsigned LUT_ADDR_W = sine_pkg::LUT_ADDR_W,
  parameter int unsigned OUT_W      = sine_pkg::OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase_inc,
  output logic [OUT_W-1:0]   sample,
  output logic               sample_valid,
  input  logic               sample_ready
);
  import sine_pkg::*;

  localparam int unsigned Q_W = OUT_W - 1;

  logic                  advance_c;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [PHASE_W-1:0]    s1_phase_q, s1_phase_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  quad_t                 quad_q, quad_d;
  quad_t                 quad_c;
  logic [LUT_ADDR_W-1:0] rom_addr_c;
  logic [Q_W-1:0]        rom_data;
  logic [OUT_W-1:0]      sample_q, sample_d;
  logic                  sample_valid_q, sample_valid_d;

  assign advance_c = !sample_valid_q || sample_ready;

  sine_quarter_rom #(
    .ADDR_W (LUT_ADDR_W),
    .DATA_W (Q_W)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .rd_en (advance_c),
    .addr  (rom_addr_c),
    .data  (rom_data)
  );

  // Odd quadrants run the quarter wave backwards; half-sample offset makes ~addr exact
  always_comb begin
    quad_c     = quad_t'(s1_phase_q[PHASE_W-1 -: 2]);
    rom_addr_c = s1_phase_q[PHASE_W-3 -: LUT_ADDR_W];
    if (quad_c == Q1 || quad_c == Q3) begin
      rom_addr_c = ~rom_addr_c;
    end
  end

  always_comb begin
    phase_d        = phase_q;
    s1_phase_d     = s1_phase_q;
    s1_valid_d     = s1_valid_q;
    s2_valid_d     = s2_valid_q;
    quad_d         = quad_q;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    if (advance_c) begin
      if (en) begin
        s1_phase_d = phase_q;
        phase_d    = phase_q + phase_inc;
      end
      s1_valid_d     = en;
      quad_d         = quad_c;
      s2_valid_d     = s1_valid_q;
      sample_valid_d = s2_valid_q;
      // Bubbles leave the last real sample on the pins
      if (s2_valid_q) begin
        if (quad_q == Q2 || quad_q == Q3) begin
          sample_d = OUT_W'(MIDSCALE - 1) - OUT_W'(rom_data);
        end else begin
          sample_d = OUT_W'(MIDSCALE) + OUT_W'(rom_data);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q        <= '0;
      s1_phase_q     <= '0;
      s1_valid_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
      quad_q         <= Q0;
      sample_q       <= OUT_W'(MIDSCALE);
      sample_valid_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      s1_phase_q     <= s1_phase_d;
      s1_valid_q     <= s1_valid_d;
      s2_valid_q     <= s2_valid_d;
      quad_q         <= quad_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule
